// File: rtl/fpu_cmd_queue.sv
// Host bus front-end for the FPU core: operand staging, command FIFO, issue FSM, result FIFO.
// Optional core watchdog compiled in with `define FPU_Q_TIMEOUT_EN.
module fpu_cmd_queue #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 4,
  parameter int CMD_DEPTH   = 4,
  parameter int RES_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] databus_in,
  output logic [DATA_W-1:0] databus_out,
  input  logic [3:0]        addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic              end_ack,
  output logic              cmd_end,
  output logic              busy,
  output logic              core_start,
  output logic [OP_W-1:0]   core_op,
  output logic [31:0]       core_a,
  output logic [31:0]       core_b,
  input  logic              core_done,
  input  logic [31:0]       core_result
);
  localparam int NW  = 32 / DATA_W;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
  } cmd_t;

  logic [1:0]        state, state_n;
  logic              wr_q, ack_q, wr_evt;
  logic [31:0]       stg_a, stg_b;
  logic [OP_W-1:0]   stg_op;
  logic              ovf, tmo_flag, tmo_hit;
  logic [31:0]       held;
  logic              hold_ld;

  cmd_t              cmd_mem [CMD_DEPTH];
  logic [CAW:0]      cwp, crp;
  logic              cmd_full, cmd_empty, cmd_push, cmd_pop, host_push;
  cmd_t              cmd_head;

  logic [31:0]       res_mem [RES_DEPTH];
  logic [RAW:0]      rwp, rrp;
  logic              res_full, res_empty, res_push, res_pop, res_room;
  logic [31:0]       res_wdata, res_head;

  logic [DATA_W-1:0] status_w, rdata;

  // A write strobe held low across several edges is a single access.
  assign wr_evt    = !cs && !wr && wr_q;
  assign host_push = wr_evt && (addr == 4'd9);

  assign cmd_full  = (cwp[CAW] != crp[CAW]) && (cwp[CAW-1:0] == crp[CAW-1:0]);
  assign cmd_empty = (cwp == crp);
  assign cmd_push  = host_push && (!cmd_full || cmd_pop);
  assign cmd_head  = cmd_mem[crp[CAW-1:0]];

  assign res_full  = (rwp[RAW] != rrp[RAW]) && (rwp[RAW-1:0] == rrp[RAW-1:0]);
  assign res_empty = (rwp == rrp);
  assign res_pop   = end_ack && !ack_q && !res_empty;
  assign res_room  = !res_full || res_pop;
  assign res_head  = res_mem[rrp[RAW-1:0]];

  assign cmd_end = !res_empty;
  assign busy    = (state != S_IDLE) || !cmd_empty;

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cwp[CAW-1:0]] <= '{op: stg_op, a: stg_a, b: stg_b};
    if (res_push) res_mem[rwp[RAW-1:0]] <= res_wdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q   <= 1'b1;
      ack_q  <= 1'b0;
      stg_a  <= '0;
      stg_b  <= '0;
      stg_op <= '0;
    end else begin
      wr_q  <= wr;
      ack_q <= end_ack;
      if (wr_evt) begin
        for (int k = 0; k < NW; k++) begin
          if (addr == 4'(k))     stg_a[k*DATA_W +: DATA_W] <= databus_in;
          if (addr == 4'(4 + k)) stg_b[k*DATA_W +: DATA_W] <= databus_in;
        end
        if (addr == 4'd8) stg_op <= databus_in[OP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cwp <= '0;
      crp <= '0;
      rwp <= '0;
      rrp <= '0;
      ovf <= 1'b0;
    end else begin
      if (cmd_push) cwp <= cwp + 1'b1;
      if (cmd_pop)  crp <= crp + 1'b1;
      if (res_push) rwp <= rwp + 1'b1;
      if (res_pop)  rrp <= rrp + 1'b1;
      if (host_push && cmd_full && !cmd_pop) ovf <= 1'b1;
      else if (wr_evt && addr == 4'hE)       ovf <= 1'b0;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_pop   = 1'b0;
    res_push  = 1'b0;
    res_wdata = core_result;
    hold_ld   = 1'b0;
    case (state)
      S_IDLE:  if (!cmd_empty) state_n = S_ISSUE;
      S_ISSUE: begin
        cmd_pop = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: if (core_done || tmo_hit) begin
        res_wdata = core_done ? core_result : QNAN;
        if (res_room) begin
          res_push = 1'b1;
          state_n  = S_IDLE;
        end else begin
          hold_ld = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        res_wdata = held;
        if (res_room) begin
          res_push = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      held       <= '0;
      core_start <= 1'b0;
      core_op    <= '0;
      core_a     <= '0;
      core_b     <= '0;
    end else begin
      state      <= state_n;
      core_start <= (state == S_ISSUE);
      if (hold_ld) held <= res_wdata;
      if (state == S_ISSUE) begin
        core_op <= cmd_head.op;
        core_a  <= cmd_head.a;
        core_b  <= cmd_head.b;
      end
    end
  end

`ifdef FPU_Q_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == S_ISSUE)                 tmo_cnt <= '0;
      else if (state == S_WAIT && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit && !core_done)            tmo_flag <= 1'b1;
      else if (wr_evt && addr == 4'hE)      tmo_flag <= 1'b0;
    end
  end
`else
  // Watchdog compiled out: never fires, flag reads 0.
  assign tmo_hit  = (TIMEOUT_CYC < 0);
  assign tmo_flag = 1'b0;
`endif

  always_comb begin
    status_w      = '0;
    status_w[4:0] = {tmo_flag, ovf, res_empty, cmd_empty, cmd_full};
  end

  always_comb begin
    rdata = '0;
    if (!cs && !rd) begin
      if (addr == 4'hE) rdata = status_w;
      for (int k = 0; k < NW; k++)
        if (!res_empty && addr == 4'(9 + k)) rdata = res_head[k*DATA_W +: DATA_W];
    end
  end
  assign databus_out = rdata;

endmodule

// File: doc/fpu_cmd_queue.md
Name: fpu_cmd_queue

Overview:
Host-side bus front-end for the FPU core, with a parametrised bus width. Provides staging registers for operands and opcode, and a command FIFO so the host can queue several operations without waiting for each to finish. An issue FSM feeds the core one command at a time and collects results into a result FIFO. The cmd_end/end_ack interrupt handshake is extended to queued results.

Parameters:
DATA_W, 8, host bus width; legal values 8, 16, 32. Words per operand NW = 32/DATA_W.
OP_W, 4, opcode width (matches the FPU operation enum).
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
RES_DEPTH, 4, result FIFO entries (power of 2, >=2).
TIMEOUT_CYC, 1024, core watchdog limit; used only with FPU_Q_TIMEOUT_EN.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous reset, active low
databus_in  in  DATA_W  host write data
databus_out  out  DATA_W  host read data
addr  in  4  register address
cs  in  1  chip select, active low
rd  in  1  read strobe, active low
wr  in  1  write strobe, active low
end_ack  in  1  host acknowledge of the head result
cmd_end  out  1  result available / irq
busy  out  1  command pending or executing
core_start  out  1  one-cycle issue pulse to the FPU core
core_op  out  OP_W  opcode of the issued command
core_a  out  32  operand A of the issued command
core_b  out  32  operand B of the issued command
core_done  in  1  one-cycle completion pulse from the core
core_result  in  32  result; valid while core_done=1

Behaviour:
- Reset: all outputs 0; FIFOs empty; staging registers 0; overflow and timeout flags 0; FSM in IDLE. Reset asserted mid-operation discards all queued commands and results. No core_start is issued after reset releases unless a new push occurs.
- Write event: occurs on the first rising clk edge where cs=0 and wr=0 and wr was 1 on the previous edge. A wr held low for several cycles counts as a single write.
- Read: databus_out is combinational from addr while cs=0 and rd=0; otherwise it is 0.
- Address map, word k in 0..NW-1:
  - A word k at addr 0+k (write).
  - B word k at addr 4+k (write).
  - OP at addr 8 (write, low OP_W bits).
  - Write to 9 pushes {A,B,OP} into the command FIFO; data is ignored.
  - Read 9+k returns word k of the head result; reads 0 if the result FIFO is empty.
  - Read E returns STATUS: bit0 cmd_full, bit1 cmd_empty, bit2 res_empty, bit3 overflow, bit4 timeout, other bits 0.
  - Write E clears bits 3 and 4.
  - Unmapped addresses read 0 and ignore writes.
- Staging registers keep their values after a push, so the same operands can be reused.
- Push while the command FIFO is full: command dropped, overflow set (sticky).
- Issue FSM:
  - IDLE: if the command FIFO is non-empty, go to ISSUE.
  - ISSUE: drive core_a/b/op from the FIFO head and pulse core_start for one cycle; pop the command FIFO; go to WAIT. core_a/b/op hold their values until the next ISSUE.
  - WAIT: on core_done, capture core_result. If the result FIFO is not full, push it and go to IDLE. If full, go to HOLD.
  - HOLD: push the held result as soon as the result FIFO is not full, then go to IDLE.
- Latency: with an empty queue, core_start is asserted 2 cycles after the push edge. cmd_end is asserted 1 cycle after the core_done edge, with result space available.
- cmd_end = result FIFO not empty.
- Each rising edge of end_ack (sampled on clk) pops one result; cmd_end deasserts when the result FIFO becomes empty.
- Simultaneous events:
  - A pop and a push on the same FIFO in the same cycle are both honoured, including when the FIFO is full.
  - A host push while ISSUE is popping the same FIFO is legal.
- busy = (FSM != IDLE) or command FIFO not empty.
- FIFO pointers wrap modulo depth; full/empty are derived from an extra pointer bit.

Optional Feature:
FPU_Q_TIMEOUT_EN.
- Defined: a counter runs in WAIT. When it reaches TIMEOUT_CYC without core_done, the FSM pushes 32'h7FC00000 (qNaN) as the result, sets STATUS timeout (sticky) and returns to IDLE. A late core_done is then ignored until the next ISSUE.
- Undefined: no counter exists; WAIT waits indefinitely; STATUS bit4 reads 0.

Test Plan:
- DATA_W=8: write A=0x3F800000 and B=0x4CBEBC20 bytewise, OP=div, write 9 -> core_start pulses with core_a=3F800000, core_b=4CBEBC20. Core model returns 0x322BCC77 -> cmd_end=1; reads of 9..C give 77,CC,2B,32; end_ack -> cmd_end=0, busy=0.
- Push 3 commands back-to-back before any core_done -> exactly 3 core_start pulses, in push order, each after the previous core_done; results read back in the same order.
- CMD_DEPTH=4 with the core stalled: 6 pushes (one issued, four queued, one dropped) -> STATUS bit3=1. Write E -> bit3=0.
- RES_DEPTH=2: complete 3 commands without end_ack -> FSM holds in HOLD, busy=1. One end_ack -> third result enters the FIFO; 2 results remain.
- Assert arst_n low in WAIT with 2 queued commands -> all outputs 0, STATUS=0x06. After release, no core_start occurs.
- FPU_Q_TIMEOUT_EN, TIMEOUT_CYC=16, core never responds -> after 16 WAIT cycles the result 0x7FC00000 is queued, cmd_end=1, STATUS bit4=1. Repeat with DATA_W=32: a single read of addr 9 returns 7FC00000.
